// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop bank: mode field type and encodings.
package jk_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK  = 2'b00;
  localparam mode_t MODE_D   = 2'b01;
  localparam mode_t MODE_T   = 2'b10;
  localparam mode_t MODE_CNT = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single-bit edge-triggered JK flip-flop with async active-low reset,
// clock enable and a synchronous load path that overrides the enable.
module jk_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_r;

  // State update: reset, then load, then enabled JK action, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= RST_BIT;
    end else if (load) begin
      q_r <= d;
    end else if (en) begin
      case ({j, k})
        2'b00:   q_r <= q_r;
        2'b01:   q_r <= 1'b0;
        2'b10:   q_r <= 1'b1;
        2'b11:   q_r <= ~q_r;
        default: q_r <= q_r;
      endcase
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-cell JK flip-flop bank with runtime JK / D / T / modulo-MOD counter
// modes; counting reuses each cell's load path with a next value computed here.
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH   = 4,
  parameter longint unsigned    MOD     = 64'd16,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  mode_t             mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              tc
);

  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] j_cell_s;
  logic [WIDTH-1:0] k_cell_s;
  logic [WIDTH-1:0] load_cell_s;
  logic [WIDTH-1:0] d_cell_s;
  logic [WIDTH-1:0] cnt_next_s;
  logic [WIDTH-1:0] din_eff_s;
  logic             tc_next_s;
  logic             tc_r;

  // Map D and T modes onto JK inputs; COUNT drives the cells through load.
  always_comb begin
    j_cell_s = j;
    k_cell_s = k;
    case (mode)
      MODE_JK:  begin j_cell_s = j;            k_cell_s = k;            end
      MODE_D:   begin j_cell_s = j;            k_cell_s = ~j;           end
      MODE_T:   begin j_cell_s = j;            k_cell_s = j;            end
      MODE_CNT: begin j_cell_s = {WIDTH{1'b0}}; k_cell_s = {WIDTH{1'b0}}; end
      default:  begin j_cell_s = j;            k_cell_s = k;            end
    endcase
  end

  // Modulo counter next value; an out-of-range state restarts at zero.
  always_comb begin
    cnt_next_s = q_s;
    if (!j[0]) begin
      cnt_next_s = q_s;
    end else if ({1'b0, q_s} >= MOD_X) begin
      cnt_next_s = {WIDTH{1'b0}};
    end else if (!k[0]) begin
      cnt_next_s = (q_s == MOD_M1) ? {WIDTH{1'b0}} : q_s + ONE;
    end else begin
      cnt_next_s = (q_s == {WIDTH{1'b0}}) ? MOD_M1 : q_s - ONE;
    end
  end

  assign din_eff_s   = (mode == MODE_CNT) ? WIDTH'({1'b0, din} % MOD_X) : din;
  assign load_cell_s = (load || (en && (mode == MODE_CNT))) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign d_cell_s    = load ? din_eff_s : cnt_next_s;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell #(
        .RST_BIT (RST_VAL[gi])
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .load  (load_cell_s[gi]),
        .d     (d_cell_s[gi]),
        .j     (j_cell_s[gi]),
        .k     (k_cell_s[gi]),
        .q     (q_s[gi])
      );
    end
  endgenerate

  // Terminal count flags the edge on which the counter lands on its wrap point.
  always_comb begin
    tc_next_s = 1'b0;
    if (load) begin
      tc_next_s = 1'b0;
    end else if (!en) begin
      tc_next_s = tc_r;
    end else if ((mode == MODE_CNT) && j[0]) begin
      tc_next_s = k[0] ? (cnt_next_s == {WIDTH{1'b0}}) : (cnt_next_s == MOD_M1);
    end else begin
      tc_next_s = 1'b0;
    end
  end

  // Terminal count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_r <= 1'b0;
    end else begin
      tc_r <= tc_next_s;
    end
  end

  assign q    = q_s;
  assign qbar = ~q_s;
  assign tc   = tc_r;

endmodule
